// File: rtl/dctc_window_scheduler.sv
// Per-window sequencer for the dctc distance/threshold block with a K-of-M
// vote over recent window decisions driving a debounced seizure alarm.
module dctc_window_scheduler #(
  parameter int unsigned VOTE_WINDOW = 8,
  parameter int unsigned VOTE_THRESH = 5,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned CLR_CYC     = 2,
  parameter int unsigned CAPTURE_DLY = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic       window_ready,
  input  logic       mcmc_valid,
  output logic       dctc_rst_n,
  output logic       dctc_start,
  input  logic       dctc_finish,
  input  logic       dctc_pred,
  output logic       window_ack,
  output logic       pred_valid,
  output logic       pred_bit,
  output logic [3:0] hist_count,
  output logic       alarm,
  output logic       timeout_err,
  input  logic       err_clr
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + CLR_CYC + CAPTURE_DLY + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, START, RUN, CAPTURE, UPDATE, ACK} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [VOTE_WINDOW-1:0] history;
  logic [3:0]             ones;

  always_comb begin
    ones = '0;
    for (int unsigned i = 0; i < VOTE_WINDOW; i++) ones = ones + 4'(history[i]);
  end

  // history shifts on entry to UPDATE, so the registered count and alarm
  // become visible in the ACK cycle that follows UPDATE
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist_count <= '0;
      alarm      <= 1'b0;
    end else begin
      hist_count <= ones;
      alarm      <= (ones >= 4'(VOTE_THRESH));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      history     <= '0;
      dctc_rst_n  <= 1'b0;
      dctc_start  <= 1'b0;
      window_ack  <= 1'b0;
      pred_valid  <= 1'b0;
      pred_bit    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dctc_rst_n <= 1'b1;
      dctc_start <= 1'b0;
      window_ack <= 1'b0;
      pred_valid <= 1'b0;
      if (err_clr) timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && window_ready && mcmc_valid) begin
            state      <= CLEAR;
            cnt        <= '0;
            dctc_rst_n <= 1'b0;
          end
        end
        CLEAR: begin
          if (cnt == CW'(CLR_CYC - 1)) begin
            state      <= START;
            dctc_start <= 1'b1;
          end else begin
            cnt        <= cnt + 1'b1;
            dctc_rst_n <= 1'b0;
          end
        end
        START: begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          if (dctc_finish) begin
            state <= CAPTURE;
            cnt   <= '0;
          end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
            state       <= ACK;
            window_ack  <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (cnt == CW'(CAPTURE_DLY - 1)) begin
            state      <= UPDATE;
            pred_bit   <= dctc_pred;
            pred_valid <= 1'b1;
            history    <= (history << 1) | VOTE_WINDOW'(dctc_pred);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        UPDATE: begin
          state      <= ACK;
          window_ack <= 1'b1;
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dctc_window_scheduler.sv
// Randomized bench for dctc_window_scheduler: per-window timelines are
// derived from the latency rules and a queue-based K-of-M vote model.
module tb_dctc_window_scheduler;

  localparam int M   = 8;
  localparam int K   = 5;
  localparam int TO  = 64;
  localparam int CLR = 2;
  localparam int CAP = 1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable, window_ready, mcmc_valid;
  logic       dctc_rst_n, dctc_start, dctc_finish, dctc_pred;
  logic       window_ack, pred_valid, pred_bit, alarm, timeout_err, err_clr;
  logic [3:0] hist_count;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  bit hist_q[$];
  bit last_pred = 1'b0;
  bit te = 1'b0;

  dctc_window_scheduler #(
    .VOTE_WINDOW(M),
    .VOTE_THRESH(K),
    .TIMEOUT_CYC(TO),
    .CLR_CYC(CLR),
    .CAPTURE_DLY(CAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .enable(enable),
    .window_ready(window_ready),
    .mcmc_valid(mcmc_valid),
    .dctc_rst_n(dctc_rst_n),
    .dctc_start(dctc_start),
    .dctc_finish(dctc_finish),
    .dctc_pred(dctc_pred),
    .window_ack(window_ack),
    .pred_valid(pred_valid),
    .pred_bit(pred_bit),
    .hist_count(hist_count),
    .alarm(alarm),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ones_model();
    int s = 0;
    foreach (hist_q[i]) s += int'(hist_q[i]);
    return s;
  endfunction

  // advance to the next falling edge and fold last cycle's err_clr / timeout
  // into the expected sticky flag (a timeout in that cycle beats the clear)
  task automatic tick(input bit timeout_now);
    @(negedge clk);
    if (timeout_now) te = 1'b1;
    else if (err_clr) te = 1'b0;
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, ".rst_n"}, dctc_rst_n, 1);
    chk({tag, ".start"}, dctc_start, 0);
    chk({tag, ".pvalid"}, pred_valid, 0);
    chk({tag, ".ack"}, window_ack, 0);
    chk({tag, ".terr"}, timeout_err, te);
    chk({tag, ".pbit"}, pred_bit, last_pred);
    chk({tag, ".hcnt"}, hist_count, ones_model());
    chk({tag, ".alarm"}, alarm, ones_model() >= K);
  endtask

  // d: cycles from dctc_start to dctc_finish (d > TO means never finishes)
  task automatic run_window(input int d, input bit p, input bit tie_clr);
    bit to;
    int r, t_last, t_pv, t_ack, c_old, c_new;
    bit pb_old;
    to     = (d > TO);
    r      = to ? TO : d;
    t_last = CLR + 1 + r;
    t_pv   = to ? -1 : t_last + CAP + 1;
    t_ack  = to ? t_last + 1 : t_pv + 1;

    tick(0);
    idle_outputs("win_idle");
    c_old  = ones_model();
    pb_old = last_pred;
    if (!to) begin
      hist_q.push_back(p);
      if (hist_q.size() > M) void'(hist_q.pop_front());
      last_pred = p;
    end
    c_new = ones_model();

    enable = 1'b1; window_ready = 1'b1; mcmc_valid = 1'b1;
    dctc_finish = 1'b0; dctc_pred = 1'($urandom);
    err_clr = ($urandom_range(0, 7) == 0);

    for (int k = 1; k <= t_ack; k++) begin
      tick(to && (k - 1 == t_last));
      chk("rst_n", dctc_rst_n, !(k <= CLR));
      chk("start", dctc_start, k == CLR + 1);
      chk("pvalid", pred_valid, k == t_pv);
      chk("ack", window_ack, k == t_ack);
      chk("terr", timeout_err, te);
      chk("pbit", pred_bit, (!to && k >= t_pv) ? p : pb_old);
      chk("hcnt", hist_count, (k >= t_ack) ? c_new : c_old);
      chk("alarm", alarm, ((k >= t_ack) ? c_new : c_old) >= K);
      enable       = 1'($urandom);
      window_ready = 1'($urandom);
      mcmc_valid   = 1'($urandom);
      dctc_finish  = (k >= CLR + 1 + d);
      if (!to && k == t_last)            dctc_pred = ~p;
      else if (!to && k == t_last + CAP) dctc_pred = p;
      else                               dctc_pred = 1'($urandom);
      err_clr = (tie_clr && k == t_last) ? 1'b1 : ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic idle_check(input int n, input bit en, input bit rdy, input bit mv);
    tick(0);
    enable = en; window_ready = rdy; mcmc_valid = mv;
    dctc_finish = 1'b0;
    err_clr = ($urandom_range(0, 3) == 0);
    for (int k = 0; k < n; k++) begin
      tick(0);
      idle_outputs("gate");
      err_clr = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic pulse_clr();
    tick(0);
    enable = 1'b0;
    err_clr = 1'b1;
    tick(0);
    err_clr = 1'b0;
    chk("err_clr", timeout_err, 0);
  endtask

  task automatic reset_mid_run();
    tick(0);
    enable = 1'b1; window_ready = 1'b1; mcmc_valid = 1'b1;
    dctc_finish = 1'b0; err_clr = 1'b0;
    for (int k = 1; k <= CLR + 4; k++) tick(0);
    reset_n = 1'b0;
    enable  = 1'b0;
    #1;
    hist_q.delete();
    last_pred = 1'b0;
    te = 1'b0;
    chk("arst.rst_n", dctc_rst_n, 0);
    chk("arst.start", dctc_start, 0);
    chk("arst.ack", window_ack, 0);
    chk("arst.pvalid", pred_valid, 0);
    chk("arst.pbit", pred_bit, 0);
    chk("arst.hcnt", hist_count, 0);
    chk("arst.alarm", alarm, 0);
    chk("arst.terr", timeout_err, 0);
    @(negedge clk);
    reset_n = 1'b1;
    tick(0);
    idle_outputs("arst_rel");
  endtask

  initial begin
    reset_n = 1'b0;
    enable = 1'b0; window_ready = 1'b0; mcmc_valid = 1'b0;
    dctc_finish = 1'b0; dctc_pred = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.rst_n", dctc_rst_n, 0);
    chk("rst.hcnt", hist_count, 0);
    chk("rst.alarm", alarm, 0);
    chk("rst.terr", timeout_err, 0);
    reset_n = 1'b1;
    tick(0);
    idle_outputs("rel");

    run_window(9, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) run_window(3 + i, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) run_window(5 + i, 1'b0, 1'b0);

    run_window(1000, 1'b1, 1'b0);
    pulse_clr();
    run_window(1000, 1'b0, 1'b1);
    run_window(TO, 1'b1, 1'b0);

    idle_check(8, 1'b1, 1'b1, 1'b0);
    run_window(12, 1'b1, 1'b0);
    idle_check(8, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 30; i++) begin
      int d;
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(1, 20);
      run_window(d, 1'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) idle_check(3, 1'b0, 1'($urandom), 1'($urandom));
    end

    reset_mid_run();
    run_window(4, 1'b1, 1'b0);
    run_window(7, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dctc_window_scheduler.md
Name: dctc_window_scheduler

Overview:
- Sequences the dctc distance/threshold block once per EEG analysis window and votes over recent per-window decisions to raise a debounced seizure alarm.
- Sits between the sample FIFO / MCMC engine and dctc. Per window it:
  - clears dctc's sticky state;
  - issues the start pulse;
  - waits for completion and captures the prediction;
  - releases the FIFO window.
- A K-of-M vote over the last M window decisions drives the alarm.

Parameters:
- VOTE_WINDOW, 8, number of most recent window decisions kept in history (M, 1..15).
- VOTE_THRESH, 5, minimum count of positive decisions in history to assert alarm (K, 1..M).
- TIMEOUT_CYC, 64, max cycles from dctc_start to dctc_finish before the window is aborted.
- CLR_CYC, 2, cycles dctc_rst_n is held low before each start.
- CAPTURE_DLY, 1, cycles after first dctc_finish==1 before seizure_prediction is sampled.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  level; 1 allows new windows to be scheduled.
- window_ready  in  1  level; FIFO holds a complete window.
- mcmc_valid  in  1  level; MCMC sample outputs feeding dctc are stable.
- dctc_rst_n  out  1  active-low reset driven to dctc.
- dctc_start  out  1  one-cycle start pulse to dctc.
- dctc_finish  in  1  dctc completion flag (sticky until dctc reset).
- dctc_pred  in  1  dctc seizure_prediction.
- window_ack  out  1  one-cycle pulse; FIFO may advance to the next window.
- pred_valid  out  1  one-cycle pulse; pred_bit is valid.
- pred_bit  out  1  captured decision of the last window.
- hist_count  out  4  number of 1s in the history register.
- alarm  out  1  registered vote result.
- timeout_err  out  1  sticky; a window timed out.
- err_clr  in  1  synchronous clear of timeout_err.

Behaviour:
- Reset:
  - Outputs: dctc_rst_n=0, dctc_start=0, window_ack=0, pred_valid=0, pred_bit=0, hist_count=0, alarm=0, timeout_err=0.
  - Internal state: history=0, state=IDLE.
  - dctc_rst_n goes 1 on the first clock after reset release.
- All outputs are registered; no combinational input-to-output paths.
- FSM states: IDLE, CLEAR, START, RUN, CAPTURE, UPDATE, ACK.
  - IDLE: when enable & window_ready & mcmc_valid -> CLEAR. Otherwise stay.
  - CLEAR: dctc_rst_n=0 for exactly CLR_CYC cycles, then -> START. dctc_rst_n returns to 1 in the START cycle.
  - START: dctc_start=1 for exactly one cycle; timeout counter loads 0; -> RUN.
  - RUN: counter increments each cycle.
    - dctc_finish==1 -> CAPTURE.
    - Else counter==TIMEOUT_CYC-1 -> timeout path: timeout_err<=1, pred_valid stays 0, history unchanged, -> ACK.
    - dctc_finish wins if both occur in the same cycle.
  - CAPTURE: wait CAPTURE_DLY cycles, then register pred_bit<=dctc_pred; -> UPDATE.
  - UPDATE: history<={history[M-2:0],pred_bit}; pred_valid=1 for one cycle; -> ACK.
  - ACK: window_ack=1 for one cycle; -> IDLE.
- Vote logic:
  - hist_count = popcount(history), registered one cycle after the history update.
  - alarm updates on the same edge as hist_count: alarm=(popcount>=VOTE_THRESH).
  - alarm changes only in the cycle following UPDATE.
- Latency from IDLE trigger to window_ack: 1+CLR_CYC+1+R+CAPTURE_DLY+1+1 cycles, where R is the number of RUN cycles.
- Minimum gap between windows: one IDLE cycle after ACK.
- enable deasserted mid-window: the current window completes through ACK; the next window is not started until enable=1.
- window_ready or mcmc_valid dropping after IDLE is ignored until the next IDLE.
- err_clr:
  - clears timeout_err in any state;
  - if err_clr and a new timeout coincide, the set wins.
- History wrap: the oldest bit is discarded on each shift; there is no saturation issue since hist_count<=M<=15.

Test Plan:
- Single window: enable=1, ready=1, mcmc_valid=1, dctc_finish rises 9 cycles after dctc_start, dctc_pred=1 -> dctc_rst_n low 2 cycles, one dctc_start, pred_bit=1, pred_valid pulse, window_ack one cycle after pred_valid, hist_count=1, alarm=0.
- Vote threshold: 5 consecutive windows with pred=1 -> hist_count=5 and alarm=1 after the 5th UPDATE. Then 4 windows with pred=0 -> hist_count drops to 4 once the first 1 shifts out (9th window), and alarm=0.
- Timeout: dctc_finish held 0 -> after 64 RUN cycles timeout_err=1, no pred_valid, history unchanged, window_ack pulses. Asserting err_clr clears timeout_err. Asserting err_clr coincident with a second timeout -> timeout_err stays 1.
- Gating: mcmc_valid=0 with ready=1 -> no dctc_start. Dropping enable during RUN -> window completes with ack, then stays IDLE.
- Async reset mid-RUN: assert reset_n=0 -> all outputs at reset values immediately, history=0. After release, dctc_rst_n=1 next cycle and the FSM restarts from IDLE.
- Finish/timeout tie: dctc_finish rises exactly in the cycle counter==63 -> CAPTURE path taken, timeout_err stays 0.
